// File: rtl/msix_intr_gen.sv
// MSI-X message generator: per-vector table + PBA, round-robin arbitration of
// eligible pending vectors onto a single-DW memory-write request channel.
module msix_intr_gen #(
  parameter int NUM_VEC = 8,
  parameter int IDX_W   = $clog2(NUM_VEC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               msix_en,
  input  logic               func_mask,
  input  logic               tbl_wr_en,
  input  logic [IDX_W-1:0]   tbl_wr_idx,
  input  logic [1:0]         tbl_wr_sel,
  input  logic [31:0]        tbl_wr_data,
  input  logic [NUM_VEC-1:0] intr_req,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [63:0]        wr_addr,
  output logic [31:0]        wr_data,
  output logic [NUM_VEC-1:0] pba,
  output logic               intr_sent,
  output logic [IDX_W-1:0]   intr_sent_id
);

  localparam logic [IDX_W:0] NUM_VEC_W = (IDX_W+1)'(NUM_VEC);

  typedef enum logic {IDLE, ISSUE} state_t;

  logic [NUM_VEC-1:0][31:0] tbl_addr_lo;
  logic [NUM_VEC-1:0][31:0] tbl_addr_hi;
  logic [NUM_VEC-1:0][31:0] tbl_data;
  logic [NUM_VEC-1:0]       tbl_mask;

  state_t             state_q;
  logic [NUM_VEC-1:0] pba_q, pba_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   sel_q;
  logic               wr_valid_q;
  logic [63:0]        wr_addr_q;
  logic [31:0]        wr_data_q;
  logic               intr_sent_q;
  logic [IDX_W-1:0]   intr_sent_id_q;

  logic [NUM_VEC-1:0] elig;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     cand;
  logic               hs;

  // Indices >= NUM_VEC match no entry, so such writes are dropped.
  for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_vec
    logic [31:0] addr_lo_q, addr_hi_q, data_q;
    logic        mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        addr_lo_q <= '0;
        addr_hi_q <= '0;
        data_q    <= '0;
        mask_q    <= 1'b1;
      end else if (tbl_wr_en && tbl_wr_idx == IDX_W'(gi)) begin
        case (tbl_wr_sel)
          2'd0:    addr_lo_q <= {tbl_wr_data[31:2], 2'b00};
          2'd1:    addr_hi_q <= tbl_wr_data;
          2'd2:    data_q    <= tbl_wr_data;
          default: mask_q    <= tbl_wr_data[0];
        endcase
      end
    end

    assign tbl_addr_lo[gi] = addr_lo_q;
    assign tbl_addr_hi[gi] = addr_hi_q;
    assign tbl_data[gi]    = data_q;
    assign tbl_mask[gi]    = mask_q;
  end

  assign elig = pba_q & ~tbl_mask & {NUM_VEC{msix_en & ~func_mask}};
  assign hs   = (state_q == ISSUE) && wr_ready;

  // Search starts just after the last winner and wraps, ending on the winner itself.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_VEC; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= NUM_VEC_W) cand = cand - NUM_VEC_W;
      if (!pick_found && elig[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // A request landing on the clearing edge wins, so the vector stays pending.
  always_comb begin
    pba_d = pba_q;
    if (hs) pba_d[sel_q] = 1'b0;
    pba_d = pba_d | intr_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pba_q          <= '0;
      rr_ptr_q       <= IDX_W'(NUM_VEC - 1);
      sel_q          <= '0;
      wr_valid_q     <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      intr_sent_q    <= 1'b0;
      intr_sent_id_q <= '0;
    end else begin
      pba_q       <= pba_d;
      intr_sent_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            sel_q      <= pick_idx;
            wr_addr_q  <= {tbl_addr_hi[pick_idx], tbl_addr_lo[pick_idx]};
            wr_data_q  <= tbl_data[pick_idx];
            wr_valid_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (wr_ready) begin
            wr_valid_q     <= 1'b0;
            rr_ptr_q       <= sel_q;
            intr_sent_q    <= 1'b1;
            intr_sent_id_q <= sel_q;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign pba          = pba_q;
  assign intr_sent    = intr_sent_q;
  assign intr_sent_id = intr_sent_id_q;

endmodule

// File: tb/tb_msix_intr_gen.sv
// Self-checking bench for msix_intr_gen: scoreboard of expected messages,
// popped by a monitor at each write handshake.
module tb_msix_intr_gen;
  localparam int NV = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          msix_en = 1'b0;
  logic          func_mask = 1'b0;
  logic          tbl_wr_en = 1'b0;
  logic [IW-1:0] tbl_wr_idx = '0;
  logic [1:0]    tbl_wr_sel = '0;
  logic [31:0]   tbl_wr_data = '0;
  logic [NV-1:0] intr_req = '0;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [63:0]   wr_addr;
  logic [31:0]   wr_data;
  logic [NV-1:0] pba;
  logic          intr_sent;
  logic [IW-1:0] intr_sent_id;

  msix_intr_gen #(.NUM_VEC(NV)) dut (
    .clk(clk), .rst_n(rst_n), .msix_en(msix_en), .func_mask(func_mask),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx), .tbl_wr_sel(tbl_wr_sel),
    .tbl_wr_data(tbl_wr_data), .intr_req(intr_req), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .pba(pba),
    .intr_sent(intr_sent), .intr_sent_id(intr_sent_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [63:0]   addr;
    logic [31:0]   data;
  } msg_t;

  msg_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] m_lo [NV];
  logic [31:0] m_hi [NV];
  logic [31:0] m_data [NV];
  logic          sent_pend = 1'b0;
  logic [IW-1:0] sent_id = '0;

  // Monitor: a handshake seen at negedge completes on the next posedge.
  always @(negedge clk) begin
    msg_t e;
    if (rst_n) begin
      if (sent_pend) begin
        checks++;
        if (intr_sent !== 1'b1 || intr_sent_id !== sent_id) begin
          failures++;
          $display("FAIL intr_sent: got sent=%b id=%0d, want sent=1 id=%0d", intr_sent, intr_sent_id, sent_id);
        end
        sent_pend = 1'b0;
      end else if (intr_sent === 1'b1) begin
        checks++; failures++;
        $display("FAIL intr_sent_spurious: got sent=1 id=%0d, want sent=0", intr_sent_id);
      end
      if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL msg_unexpected: got addr=%h data=%h, want no message", wr_addr, wr_data);
        end else begin
          e = sb.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            failures++;
            $display("FAIL msg_vec%0d: got addr=%h data=%h, want addr=%h data=%h", e.id, wr_addr, wr_data, e.addr, e.data);
          end else
            $display("msg vec%0d addr=%h data=%h ok", e.id, wr_addr, wr_data);
          sent_id = e.id;
          sent_pend = 1'b1;
        end
      end
    end else sent_pend = 1'b0;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic tbl_write(input int idx, input logic [1:0] sel, input logic [31:0] d);
    tbl_wr_en = 1'b1; tbl_wr_idx = IW'(idx); tbl_wr_sel = sel; tbl_wr_data = d;
    tick();
    tbl_wr_en = 1'b0;
    case (sel)
      2'd0: m_lo[idx] = {d[31:2], 2'b00};
      2'd1: m_hi[idx] = d;
      2'd2: m_data[idx] = d;
      default: ;
    endcase
  endtask

  task automatic push_exp(input int idx);
    msg_t e;
    e.id = IW'(idx); e.addr = {m_hi[idx], m_lo[idx]}; e.data = m_data[idx];
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [NV-1:0] v);
    intr_req = v;
    tick();
    intr_req = '0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sb.size() == 0 && wr_valid === 1'b0 && !sent_pend) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (wr_valid !== 1'b0 || pba !== '0 || intr_sent !== 1'b0 || wr_addr !== '0 ||
        wr_data !== '0 || intr_sent_id !== '0) begin
      failures++;
      $display("FAIL reset: got valid=%b pba=%h sent=%b addr=%h data=%h id=%0d, want all 0",
               wr_valid, pba, intr_sent, wr_addr, wr_data, intr_sent_id);
    end else $display("reset values ok");
    // All vectors start masked: a request must only pend.
    rst_n = 1'b1; msix_en = 1'b1;
    pulse(8'h01);
    tick(); tick();
    checks++;
    if (wr_valid !== 1'b0 || pba !== 8'h01) begin
      failures++;
      $display("FAIL reset_mask: got valid=%b pba=%h, want valid=0 pba=01", wr_valid, pba);
    end else $display("reset mask=1 holds request ok");
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
  endtask

  task automatic program_table();
    for (int i = 0; i < NV; i++) begin
      tbl_write(i, 2'd0, 32'hFEE0_0000 | (i << 4));
      tbl_write(i, 2'd1, 32'h0);
      tbl_write(i, 2'd2, 32'h1000 + i);
      tbl_write(i, 2'd3, 32'h0);
    end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 6; i++) push_exp(i);
    pulse(8'h3F);
    checks++;
    if (pba !== 8'h3F || wr_valid !== 1'b0) begin
      failures++;
      $display("FAIL burst_pend: got pba=%h valid=%b, want pba=3f valid=0", pba, wr_valid);
    end
    repeat (11) tick();
    checks++;
    if (sb.size() != 1) begin
      failures++;
      $display("FAIL burst_rate: got %0d outstanding after 11 edges, want 1", sb.size());
    end
    tick();
    checks++;
    if (sb.size() != 0 || pba !== '0) begin
      failures++;
      $display("FAIL burst_done: got outstanding=%0d pba=%h, want 0 and 00", sb.size(), pba);
    end else $display("burst of six done at edge 12 ok");
  endtask

  task automatic test_single();
    tbl_write(2, 2'd0, 32'hFEE0_000B);
    tbl_write(2, 2'd1, 32'h1);
    tbl_write(2, 2'd2, 32'h42);
    tbl_write(2, 2'd3, 32'h0);
    push_exp(2);
    pulse(8'h04);
    checks++;
    if (pba !== 8'h04 || wr_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_e0: got pba=%h valid=%b, want pba=04 valid=0", pba, wr_valid);
    end
    tick();
    checks++;
    if (wr_valid !== 1'b1 || wr_addr !== 64'h1_FEE0_0008 || wr_data !== 32'h42) begin
      failures++;
      $display("FAIL single_e1: got valid=%b addr=%h data=%h, want 1 1fee00008 42", wr_valid, wr_addr, wr_data);
    end
    tick();
    checks++;
    if (wr_valid !== 1'b0 || pba !== '0 || intr_sent !== 1'b1 || intr_sent_id !== 3'd2) begin
      failures++;
      $display("FAIL single_e2: got valid=%b pba=%h sent=%b id=%0d, want 0 00 1 2", wr_valid, pba, intr_sent, intr_sent_id);
    end else $display("single vec2 timing ok");
  endtask

  task automatic test_masked();
    bit seen = 1'b0;
    bit ok;
    tbl_write(3, 2'd3, 32'h1);
    pulse(8'h08); tick(); pulse(8'h08);
    for (int i = 0; i < 6; i++) begin tick(); if (wr_valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen || pba !== 8'h08) begin
      failures++;
      $display("FAIL masked_hold: got seen_valid=%b pba=%h, want 0 08", seen, pba);
    end
    push_exp(3);
    tbl_write(3, 2'd3, 32'h0);
    wait_idle(10, ok);
    repeat (4) tick();
    checks++;
    if (!ok || pba !== '0 || sb.size() != 0) begin
      failures++;
      $display("FAIL masked_release: got ok=%b pba=%h outstanding=%0d, want 1 00 0", ok, pba, sb.size());
    end else $display("masked vec3 coalesced to one message ok");
  endtask

  task automatic test_stall();
    bit ok;
    bit bad = 1'b0;
    logic [63:0] ea;
    logic [31:0] ed;
    wr_ready = 1'b0;
    push_exp(1);
    ea = {m_hi[1], m_lo[1]}; ed = m_data[1];
    pulse(8'h02);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 2) tbl_write(1, 2'd2, 32'hDEAD);
      else if (i == 4) tbl_write(1, 2'd3, 32'h1);
      else if (i == 6) begin msix_en = 1'b0; func_mask = 1'b1; tick(); end
      else tick();
      if (wr_valid !== 1'b1 || wr_addr !== ea || wr_data !== ed) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stall_hold: got valid=%b addr=%h data=%h, want 1 %h %h", wr_valid, wr_addr, wr_data, ea, ed);
    end else $display("stall on vec1 held stable ok");
    msix_en = 1'b1; func_mask = 1'b0;
    tbl_write(1, 2'd3, 32'h0);
    wr_ready = 1'b1;
    wait_idle(10, ok);
    checks++;
    if (!ok || pba !== '0) begin
      failures++;
      $display("FAIL stall_release: got ok=%b pba=%h, want 1 00", ok, pba);
    end
  endtask

  task automatic test_same_edge();
    bit ok;
    push_exp(4); push_exp(4);
    pulse(8'h10);
    tick();
    checks++;
    if (wr_valid !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_valid: got %b, want 1", wr_valid);
    end
    pulse(8'h10);
    checks++;
    if (pba !== 8'h10 || intr_sent !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_pba: got pba=%h sent=%b, want 10 1", pba, intr_sent);
    end
    wait_idle(10, ok);
    checks++;
    if (!ok || pba !== '0) begin
      failures++;
      $display("FAIL same_edge_second: got ok=%b pba=%h, want 1 00", ok, pba);
    end else $display("same-edge vec4 re-request ok");
  endtask

  task automatic test_func_mask();
    bit ok;
    bit seen = 1'b0;
    func_mask = 1'b1;
    pulse(8'h0F);
    for (int i = 0; i < 6; i++) begin tick(); if (wr_valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen || pba !== 8'h0F) begin
      failures++;
      $display("FAIL func_mask_hold: got seen_valid=%b pba=%h, want 0 0f", seen, pba);
    end
    for (int i = 0; i < 4; i++) push_exp(i);
    func_mask = 1'b0;
    wait_idle(20, ok);
    checks++;
    if (!ok || pba !== '0) begin
      failures++;
      $display("FAIL func_mask_release: got ok=%b pba=%h, want 1 00", ok, pba);
    end else $display("func_mask release sent vectors 0..3 ok");
  endtask

  task automatic test_reset_mid();
    wr_ready = 1'b0;
    pulse(8'h01);
    tick();
    checks++;
    if (wr_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_valid: got %b, want 1", wr_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wr_valid !== 1'b0 || pba !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      failures++;
      $display("FAIL reset_mid: got valid=%b pba=%h addr=%h data=%h, want all 0", wr_valid, pba, wr_addr, wr_data);
    end else $display("async reset mid-issue ok");
    tick(); rst_n = 1'b1; wr_ready = 1'b1; tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < NV; i++) begin m_lo[i] = '0; m_hi[i] = '0; m_data[i] = '0; end
    test_reset();
    program_table();
    test_burst();
    test_single();
    test_masked();
    test_stall();
    test_same_edge();
    test_func_mask();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
